// File: rtl/rtype_pipe.sv
// rtype_pipe: pipelined MIPS R-type execution unit (register file, funct decode, ALU, forwarding)
//
// Ports
//   clock        in   1     rising-edge clock
//   reset_n      in   1     asynchronous active-low reset
//   in_valid     in   1     instruction present
//   in_ready     out  1     instruction accepted this cycle when high
//   instruction  in   32    [31:26]op [25:21]rs [20:16]rt [15:11]rd [10:6]shamt [5:0]funct
//   out_valid    out  1     result stage holds a completed instruction
//   out_ready    in   1     consumer takes the result; the register write commits here
//   a_data       out  XLEN  rs operand after forwarding
//   b_data       out  XLEN  rt operand after forwarding
//   result       out  XLEN  ALU result (0 when illegal)
//   out_rd       out  AW    destination register index
//   illegal      out  1     instruction rejected, no register write
//
// Configuration
//   RTYPE_SHIFT_EN  when defined, adds sll/srl/sra (by shamt) and sllv/srlv/srav (by rs);
//                   otherwise those functs decode as illegal and no shifter is built.
module rtype_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] a_data,
    output logic [XLEN-1:0] b_data,
    output logic [XLEN-1:0] result,
    output logic [AW-1:0]   out_rd,
    output logic            illegal
);
`ifdef RTYPE_SHIFT_EN
    localparam int SW = $clog2(XLEN);
`endif

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU
`ifdef RTYPE_SHIFT_EN
        ,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA
`endif
    } alu_t;

    logic            w_stall;
    logic            w_commit;
    logic            r_s1_valid;
    logic [31:0]     r_s1_instr;
    alu_t            w_dec_op;
    logic            w_dec_bad;
    logic            w_dec_ill;
    logic            r_s2_valid;
    logic            r_s2_ill;
    alu_t            r_s2_op;
    logic [AW-1:0]   r_s2_rs;
    logic [AW-1:0]   r_s2_rt;
    logic [AW-1:0]   r_s2_rd;
    logic            w_fwd_a;
    logic            w_fwd_b;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_alu;
    logic            r_s3_valid;
    logic            r_s3_ill;
    logic [AW-1:0]   r_s3_rd;
    logic [XLEN-1:0] r_s3_a;
    logic [XLEN-1:0] r_s3_b;
    logic [XLEN-1:0] r_s3_res;
    logic [XLEN-1:0] r_regs [NREG];
`ifdef RTYPE_SHIFT_EN
    logic            w_dec_var;
    logic            r_s2_var;
    logic [4:0]      r_s2_shamt;
    logic [SW-1:0]   w_amt;
`else
    logic            w_unused_shamt;
`endif

    // A full result stage that is not being taken freezes the whole pipe;
    // an empty S1 may still fill during a stall.
    assign w_stall  = r_s3_valid && !out_ready;
    assign in_ready = reset_n && (!r_s1_valid || !w_stall);
    assign w_commit = r_s3_valid && out_ready && !r_s3_ill && (r_s3_rd != '0);

    always_comb begin
        w_dec_op  = ALU_ADD;
        w_dec_bad = 1'b0;
`ifdef RTYPE_SHIFT_EN
        w_dec_var = 1'b0;
`endif
        case (r_s1_instr[5:0])
            6'h20, 6'h21: w_dec_op = ALU_ADD;
            6'h22, 6'h23: w_dec_op = ALU_SUB;
            6'h24:        w_dec_op = ALU_AND;
            6'h25:        w_dec_op = ALU_OR;
            6'h26:        w_dec_op = ALU_XOR;
            6'h27:        w_dec_op = ALU_NOR;
            6'h2A:        w_dec_op = ALU_SLT;
            6'h2B:        w_dec_op = ALU_SLTU;
`ifdef RTYPE_SHIFT_EN
            6'h00:        w_dec_op = ALU_SLL;
            6'h02:        w_dec_op = ALU_SRL;
            6'h03:        w_dec_op = ALU_SRA;
            6'h04: begin
                w_dec_op  = ALU_SLL;
                w_dec_var = 1'b1;
            end
            6'h06: begin
                w_dec_op  = ALU_SRL;
                w_dec_var = 1'b1;
            end
            6'h07: begin
                w_dec_op  = ALU_SRA;
                w_dec_var = 1'b1;
            end
`endif
            default:      w_dec_bad = 1'b1;
        endcase
    end

    // Register index bits above AW must be zero for a small register file.
    assign w_dec_ill = (r_s1_instr[31:26] != 6'd0) || w_dec_bad
                     || (|(r_s1_instr[25:21] >> AW))
                     || (|(r_s1_instr[20:16] >> AW))
                     || (|(r_s1_instr[15:11] >> AW));

`ifndef RTYPE_SHIFT_EN
    assign w_unused_shamt = ^r_s1_instr[10:6];
`endif

    // Only S3 is ever ahead of S2 without having committed, so a single
    // forwarding path covers every data hazard, including same-cycle commit.
    assign w_fwd_a = r_s3_valid && !r_s3_ill && (r_s2_rs != '0) && (r_s2_rs == r_s3_rd);
    assign w_fwd_b = r_s3_valid && !r_s3_ill && (r_s2_rt != '0) && (r_s2_rt == r_s3_rd);
    assign w_a = (r_s2_rs == '0) ? '0 : w_fwd_a ? r_s3_res : r_regs[r_s2_rs];
    assign w_b = (r_s2_rt == '0) ? '0 : w_fwd_b ? r_s3_res : r_regs[r_s2_rt];

`ifdef RTYPE_SHIFT_EN
    assign w_amt = r_s2_var ? w_a[SW-1:0] : SW'(r_s2_shamt % XLEN);
`endif

    always_comb begin
        w_alu = '0;
        case (r_s2_op)
            ALU_ADD:  w_alu = w_a + w_b;
            ALU_SUB:  w_alu = w_a - w_b;
            ALU_AND:  w_alu = w_a & w_b;
            ALU_OR:   w_alu = w_a | w_b;
            ALU_XOR:  w_alu = w_a ^ w_b;
            ALU_NOR:  w_alu = ~(w_a | w_b);
            ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
            ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, w_a < w_b};
`ifdef RTYPE_SHIFT_EN
            ALU_SLL:  w_alu = w_b << w_amt;
            ALU_SRL:  w_alu = w_b >> w_amt;
            ALU_SRA:  w_alu = $signed(w_b) >>> w_amt;
`endif
            default:  w_alu = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_instr <= '0;
            r_s2_valid <= 1'b0;
            r_s2_ill   <= 1'b0;
            r_s2_op    <= ALU_ADD;
            r_s2_rs    <= '0;
            r_s2_rt    <= '0;
            r_s2_rd    <= '0;
`ifdef RTYPE_SHIFT_EN
            r_s2_var   <= 1'b0;
            r_s2_shamt <= '0;
`endif
            r_s3_valid <= 1'b0;
            r_s3_ill   <= 1'b0;
            r_s3_rd    <= '0;
            r_s3_a     <= '0;
            r_s3_b     <= '0;
            r_s3_res   <= '0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
                r_s1_instr <= instruction;
            end
            if (!w_stall) begin
                r_s2_valid <= r_s1_valid;
                r_s2_ill   <= w_dec_ill;
                r_s2_op    <= w_dec_op;
                r_s2_rs    <= r_s1_instr[21 +: AW];
                r_s2_rt    <= r_s1_instr[16 +: AW];
                r_s2_rd    <= r_s1_instr[11 +: AW];
`ifdef RTYPE_SHIFT_EN
                r_s2_var   <= w_dec_var;
                r_s2_shamt <= r_s1_instr[10:6];
`endif
                r_s3_valid <= r_s2_valid;
                r_s3_ill   <= r_s2_ill;
                r_s3_rd    <= r_s2_rd;
                r_s3_a     <= w_a;
                r_s3_b     <= w_b;
                r_s3_res   <= r_s2_ill ? '0 : w_alu;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (w_commit) begin
            r_regs[r_s3_rd] <= r_s3_res;
        end
    end

    assign out_valid = r_s3_valid;
    assign a_data    = r_s3_a;
    assign b_data    = r_s3_b;
    assign result    = r_s3_res;
    assign out_rd    = r_s3_rd;
    assign illegal   = r_s3_ill;

endmodule
